// File: rtl/snn_timestep_scheduler.sv
// Timestep scheduler for the 2-output SNN core: accept a sample, clear the core, step it N times,
// count output spikes and report the winner. Optional early exit under SNN_EARLY_EXIT_EN.
module snn_timestep_scheduler #(
    parameter int unsigned STEP_W  = 5,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned SNN_LAT = 1,
    parameter int unsigned MARGIN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic [STEP_W-1:0] cfg_steps,
    output logic [7:0]        snn_in,
    output logic              snn_clear,
    output logic              snn_step,
    input  logic [1:0]        snn_spikes,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_class,
    output logic              res_tie,
    output logic [CNT_W-1:0]  res_cnt0,
    output logic [CNT_W-1:0]  res_cnt1,
    output logic              res_early,
    output logic              busy
);

    localparam int unsigned LAT_W = (SNN_LAT > 1) ? $clog2(SNN_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [LAT_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [7:0]         sample_q, sample_d;
    logic [SNN_LAT-1:0] step_dly_q, step_dly_d;
    logic               accept, samp_en, early_hit, step;

    assign accept  = in_valid && in_ready;
    assign samp_en = step_dly_q[SNN_LAT-1];
    assign step    = (state_q == StRun) && !early_hit;

    // snn_step delayed by the core latency marks the cycles whose spikes belong to us
    always_comb begin
        step_dly_d    = step_dly_q << 1;
        step_dly_d[0] = step;
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (samp_en) begin
            if (snn_spikes[0] && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_W'(1);
            if (snn_spikes[1] && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

`ifdef SNN_EARLY_EXIT_EN
    logic [CNT_W-1:0] diff;
    logic             early_q;

    // Decided on the freshly updated counts so the step in this same cycle is withheld
    assign diff      = (cnt0_d >= cnt1_d) ? (cnt0_d - cnt1_d) : (cnt1_d - cnt0_d);
    assign early_hit = (state_q == StRun) && (32'(diff) >= MARGIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q <= 1'b0;
        end else if (accept) begin
            early_q <= 1'b0;
        end else if (early_hit) begin
            early_q <= 1'b1;
        end
    end

    assign res_early = (state_q == StDone) && early_q;
`else
    assign early_hit = 1'b0;
    assign res_early = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        steps_d  = steps_q;
        drain_d  = drain_q;
        sample_d = sample_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sample_d = in_data;
                    steps_d  = (cfg_steps == '0) ? STEP_W'(1) : cfg_steps;
                    state_d  = StClear;
                end
            end
            StClear: state_d = StRun;
            StRun: begin
                steps_d = steps_q - STEP_W'(1);
                drain_d = LAT_W'(SNN_LAT - 1);
                if (early_hit || (steps_q == STEP_W'(1))) state_d = StDrain;
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - LAT_W'(1);
                end
            end
            StDone: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            steps_q    <= '0;
            drain_q    <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            sample_q   <= '0;
            step_dly_q <= '0;
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            drain_q    <= drain_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            sample_q   <= sample_d;
            step_dly_q <= step_dly_d;
        end
    end

    // in_ready is held low while reset is asserted
    assign in_ready  = (state_q == StIdle) && rst_n;
    assign busy      = (state_q != StIdle);
    assign snn_in    = sample_q;
    assign snn_clear = (state_q == StClear);
    assign snn_step  = step;
    assign res_valid = (state_q == StDone);
    assign res_class = (state_q == StDone) && (cnt1_q > cnt0_q);
    assign res_tie   = (state_q == StDone) && (cnt0_q == cnt1_q);
    assign res_cnt0  = cnt0_q;
    assign res_cnt1  = cnt1_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler; a second instance with CNT_W=3 covers saturation.
module tb_snn_timestep_scheduler;

`ifdef SNN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic [4:0] cfg_steps = '0;
    logic [1:0] snn_spikes = '0;

    logic       in_ready, snn_clear, snn_step, res_valid, res_class, res_tie, res_early, busy;
    logic [7:0] snn_in;
    logic [5:0] res_cnt0, res_cnt1;

    logic       in_ready_s, snn_clear_s, snn_step_s, res_valid_s, res_class_s, res_tie_s;
    logic       res_early_s, busy_s;
    logic [7:0] snn_in_s;
    logic [2:0] res_cnt0_s, res_cnt1_s;

    int checks = 0;
    int failures = 0;
    int lat, steps, clears, seen;

    always #5 clk = ~clk;

    snn_timestep_scheduler #(.STEP_W(5), .CNT_W(6), .SNN_LAT(1), .MARGIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_steps(cfg_steps), .snn_in(snn_in), .snn_clear(snn_clear), .snn_step(snn_step),
        .snn_spikes(snn_spikes), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_tie(res_tie), .res_cnt0(res_cnt0), .res_cnt1(res_cnt1),
        .res_early(res_early), .busy(busy)
    );

    snn_timestep_scheduler #(.STEP_W(5), .CNT_W(3), .SNN_LAT(1), .MARGIN(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .cfg_steps(cfg_steps), .snn_in(snn_in_s), .snn_clear(snn_clear_s), .snn_step(snn_step_s),
        .snn_spikes(snn_spikes), .res_valid(res_valid_s), .res_ready(res_ready),
        .res_class(res_class_s), .res_tie(res_tie_s), .res_cnt0(res_cnt0_s),
        .res_cnt1(res_cnt1_s), .res_early(res_early_s), .busy(busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one sample, then scramble the inputs and wait (bounded) for res_valid
    task automatic run(input logic [7:0] d, input logic [4:0] n, input logic [1:0] sp);
        @(negedge clk);
        chk("accept_ready", in_ready, 1);
        in_data = d; cfg_steps = n; snn_spikes = sp; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; in_data = ~d; cfg_steps = 5'd31;
        lat = 0; steps = 0; clears = 0;
        do begin
            @(negedge clk);
            lat++;
            steps += int'(snn_step);
            clears += int'(snn_clear);
        end while (!res_valid && lat < 200);
    endtask

    task automatic ack();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("ack_valid_low", res_valid, 0);
        chk("ack_ready_high", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_step", snn_step, 0);
        chk("rst_clear", snn_clear, 0);
        chk("rst_snn_in", snn_in, 0);
        chk("rst_tie", res_tie, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready", in_ready, 1);

        // T2 nominal
        run(8'hA5, 5'd5, 2'b10);
        chk("t2_lat", lat, 8);
        chk("t2_steps", steps, EE ? 4 : 5);
        chk("t2_clears", clears, 1);
        chk("t2_cnt1", res_cnt1, EE ? 4 : 5);
        chk("t2_cnt0", res_cnt0, 0);
        chk("t2_class", res_class, 1);
        chk("t2_tie", res_tie, 0);
        chk("t2_early", res_early, EE ? 1 : 0);
        chk("t2_snn_in", snn_in, 8'hA5);
        chk("t2_in_ready", in_ready, 0);
        ack();

        // T3 tie, zero steps treated as one
        run(8'h3C, 5'd0, 2'b11);
        chk("t3_lat", lat, 4);
        chk("t3_steps", steps, 1);
        chk("t3_cnt0", res_cnt0, 1);
        chk("t3_cnt1", res_cnt1, 1);
        chk("t3_tie", res_tie, 1);
        chk("t3_class", res_class, 0);
        chk("t3_early", res_early, 0);

        // T4 backpressure with ignored in_valid pulses
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(in_ready);
            in_valid = ~in_valid; in_data = 8'hFF; cfg_steps = 5'd3;
        end
        in_valid = 1'b0;
        chk("t4_ready_low", seen, 0);
        chk("t4_valid", res_valid, 1);
        chk("t4_cnt0", res_cnt0, 1);
        chk("t4_tie", res_tie, 1);
        chk("t4_snn_in", snn_in, 8'h3C);
        chk("t4_busy", busy, 1);
        ack();
        chk("t4_idle", busy, 0);

        // T5 saturation on the CNT_W=3 instance
        run(8'h11, 5'd20, 2'b11);
        chk("t5_lat", lat, 23);
        chk("t5_steps", steps, 20);
        chk("t5_cnt0_wide", res_cnt0, 20);
        chk("t5_cnt0_sat", res_cnt0_s, 7);
        chk("t5_cnt1_sat", res_cnt1_s, 7);
        chk("t5_tie_sat", res_tie_s, 1);
        ack();

        // T6 early exit (or full run when the feature is off)
        run(8'h5A, 5'd16, 2'b01);
        chk("t6_steps", steps, EE ? 4 : 16);
        chk("t6_cnt0", res_cnt0, EE ? 4 : 16);
        chk("t6_lat", lat, EE ? 8 : 19);
        chk("t6_early", res_early, EE ? 1 : 0);
        chk("t6_class", res_class, 0);
        chk("t6_cnt0_s", res_cnt0_s, EE ? 4 : 7);
        ack();

        // T1 reset mid-RUN
        @(negedge clk);
        in_data = 8'h77; cfg_steps = 5'd10; snn_spikes = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_pre_step", snn_step, 1);
        chk("t1_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_step", snn_step, 0);
        chk("t1_valid", res_valid, 0);
        chk("t1_snn_in", snn_in, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t1_in_ready", in_ready, 1);
        run(8'h42, 5'd2, 2'b01);
        chk("t1_after_lat", lat, 5);
        chk("t1_after_cnt0", res_cnt0, 2);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
